// File: rtl/sa_input_skewer.sv
// Upstream feeder for the systolic array: buffers a SIZE x SIZE signed matrix row by row,
// then replays it onto the west edge as a diagonal wavefront (lane k = column k, delayed k cycles).
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_LOAD   | accepting rows, one per in_valid handshake
//   ST_FULL   | complete matrix buffered, waiting for start
//   ST_STREAM | issuing wavefronts t = 0 .. 2*SIZE-2 on registered outputs
module sa_input_skewer #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE*WIDTH-1:0] in_row,
    input  logic                  start,
    output logic                  loaded,
    output logic                  busy,
    output logic                  skew_valid,
    output logic [SIZE-1:0]       lane_valid,
    output logic [SIZE*WIDTH-1:0] skew_data,
    output logic                  done
);

    localparam int RW  = $clog2(SIZE + 1);
    localparam int TW  = $clog2(2 * SIZE);
    localparam int RIX = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic [RW-1:0] ROW_LAST = RW'(SIZE - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(2 * SIZE - 2);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_FULL   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [RW-1:0]         row_cnt;
    logic [TW-1:0]         wave_cnt;
    logic [WIDTH-1:0]      mem [SIZE][SIZE];

    logic                  row_wr;
    logic                  wave_first;
    logic                  wave_last;
    logic                  wave_adv;
    logic [TW-1:0]         wave_sel;
    logic [SIZE-1:0]       valid_nxt;
    logic [SIZE*WIDTH-1:0] data_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        row_wr     = 1'b0;
        wave_first = 1'b0;
        wave_last  = 1'b0;
        in_ready   = 1'b0;
        loaded     = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                row_wr   = in_valid;
                if (in_valid && (row_cnt == ROW_LAST)) begin
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                loaded = 1'b1;
                if (start) begin
                    wave_first = 1'b1;
                    state_nxt  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                busy = 1'b1;
                if (wave_cnt == T_LAST) begin
                    wave_last = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    assign wave_adv = busy && !wave_last;
    // Wavefront about to be registered: t=0 on the start edge, otherwise the successor.
    assign wave_sel = wave_first ? '0 : (wave_cnt + TW'(1));

    for (genvar k = 0; k < SIZE; k++) begin : g_lane
        logic [TW-1:0] row_idx;
        assign row_idx      = wave_sel - TW'(k);
        assign valid_nxt[k] = (wave_sel >= TW'(k)) && (row_idx <= TW'(SIZE - 1));
        assign data_nxt[k*WIDTH +: WIDTH] = valid_nxt[k] ? mem[RIX'(row_idx)][k] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_cnt    <= '0;
            wave_cnt   <= '0;
            lane_valid <= '0;
            skew_data  <= '0;
            done       <= 1'b0;
        end else begin
            if (row_wr) begin
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : (row_cnt + RW'(1));
            end
            if (wave_first || wave_adv) begin
                wave_cnt   <= wave_sel;
                lane_valid <= valid_nxt;
                skew_data  <= data_nxt;
            end else if (wave_last) begin
                wave_cnt   <= '0;
                lane_valid <= '0;
                skew_data  <= '0;
            end
            done <= wave_last;
        end
    end

    // Matrix storage needs no reset; rows are always rewritten before being streamed.
    always_ff @(posedge clk) begin
        if (row_wr) begin
            for (int j = 0; j < SIZE; j++) begin
                mem[RIX'(row_cnt)][j] <= in_row[j*WIDTH +: WIDTH];
            end
        end
    end

    assign skew_valid = |lane_valid;

endmodule

// File: tb/tb_sa_input_skewer.sv
// Self-checking bench for sa_input_skewer: random matrices, gapped loads, early start,
// mid-stream reset and back-to-back streaming against a direct diagonal-index model.
module tb_sa_input_skewer;

    localparam int WIDTH = 16;
    localparam int SIZE  = 10;
    localparam int NT    = 2 * SIZE - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [SIZE*WIDTH-1:0] in_row;
    logic                  start;
    logic                  loaded;
    logic                  busy;
    logic                  skew_valid;
    logic [SIZE-1:0]       lane_valid;
    logic [SIZE*WIDTH-1:0] skew_data;
    logic                  done;

    int checks = 0;
    int errors = 0;

    int a_mat   [SIZE][SIZE];
    int ld_mat  [SIZE][SIZE];
    int exp_mat [SIZE][SIZE];

    sa_input_skewer #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .start      (start),
        .loaded     (loaded),
        .busy       (busy),
        .skew_valid (skew_valid),
        .lane_valid (lane_valid),
        .skew_data  (skew_data),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic check(input string tag, input logic [SIZE*WIDTH-1:0] got,
                         input logic [SIZE*WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wavefront t: lane k shows A[t-k][k] when 0 <= t-k < SIZE.
    function automatic void wave_ref(input int t, output logic [SIZE-1:0] v,
                                     output logic [SIZE*WIDTH-1:0] d);
        v = '0;
        d = '0;
        for (int k = 0; k < SIZE; k++) begin
            int i;
            i = t - k;
            if (i >= 0 && i < SIZE) begin
                v[k] = 1'b1;
                d[k*WIDTH +: WIDTH] = WIDTH'(exp_mat[i][k]);
            end
        end
    endfunction

    task automatic reset_checks(input string tag);
        check({tag, "_in_ready"},   in_ready,   1);
        check({tag, "_loaded"},     loaded,     0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_skew_valid"}, skew_valid, 0);
        check({tag, "_done"},       done,       0);
        check({tag, "_lane_valid"}, lane_valid, 0);
        check({tag, "_skew_data"},  skew_data,  0);
    endtask

    task automatic load_rows(input int first, input int last, input int gap_max);
        for (int r = first; r <= last; r++) begin
            for (int j = 0; j < SIZE; j++) begin
                in_row[j*WIDTH +: WIDTH] = WIDTH'(ld_mat[r][j]);
            end
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (r == SIZE - 1) begin
                check("loaded_after_last_row", loaded, 1);
                check("ready_low_when_full", in_ready, 0);
            end else begin
                check("not_loaded_early", loaded, 0);
            end
            if (gap_max > 0 && r < last) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, gap_max)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic stream_check(input bit hold_start, input int abort_at);
        logic [SIZE-1:0]       v;
        logic [SIZE*WIDTH-1:0] d;
        check("idle_skew_valid_before_start", skew_valid, 0);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        for (int t = 0; t < NT; t++) begin
            wave_ref(t, v, d);
            check($sformatf("lane_valid_t%0d", t), lane_valid, v);
            check($sformatf("skew_data_t%0d", t), skew_data, d);
            check($sformatf("skew_valid_t%0d", t), skew_valid, |v);
            check($sformatf("busy_t%0d", t), busy, 1);
            check($sformatf("done_low_t%0d", t), done, 0);
            if (t == abort_at) begin
                #2 rst = 1'b0;
                #1;
                reset_checks("async_rst_mid_stream");
                repeat (2) @(posedge clk);
                #1;
                reset_checks("held_rst_mid_stream");
                rst = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        check("done_pulse", done, 1);
        check("ready_with_done", in_ready, 1);
        check("skew_valid_after", skew_valid, 0);
        check("lane_valid_after", lane_valid, 0);
        check("skew_data_after", skew_data, 0);
        check("busy_after", busy, 0);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int row0 [SIZE] = '{123, 45, 89, 200, 34, 67, 155, 210, 11, 98};
        int row9 [SIZE] = '{53, 188, 77, 199, 122, 34, 156, 89, 200, 12};

        rst      = 1'b1;
        in_valid = 1'b0;
        start    = 1'b0;
        in_row   = '0;

        #2 rst = 1'b0;
        #1;
        reset_checks("async_rst_initial");
        repeat (2) @(posedge clk);
        #1;
        reset_checks("held_rst_initial");
        rst = 1'b1;

        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                a_mat[i][j] = int'($urandom_range(0, 65535)) - 32768;
            end
        end
        for (int j = 0; j < SIZE; j++) begin
            a_mat[0][j]        = row0[j];
            a_mat[SIZE - 1][j] = row9[j];
        end
        a_mat[1][0] = 76;

        // gapped load, ignored extra row, full stream
        ld_mat  = a_mat;
        exp_mat = a_mat;
        load_rows(0, SIZE - 1, 3);
        in_row   = {SIZE{16'h7777}};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("extra_row_still_full", loaded, 1);
        stream_check(1'b0, -1);

        // start during load is ignored
        load_rows(0, 4, 2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("early_start_no_stream", skew_valid, 0);
            check("early_start_not_busy", busy, 0);
            check("early_start_ready", in_ready, 1);
            @(posedge clk); #1;
        end
        load_rows(5, SIZE - 1, 2);
        stream_check(1'b0, -1);

        // reset at t=7, then reload and stream again
        load_rows(0, SIZE - 1, 1);
        stream_check(1'b0, 7);
        load_rows(0, SIZE - 1, 3);
        stream_check(1'b0, -1);

        // start held high across an all -1 reload
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                ld_mat[i][j] = -1;
            end
        end
        exp_mat = ld_mat;
        start   = 1'b1;
        load_rows(0, SIZE - 1, 0);
        stream_check(1'b1, -1);
        start = 1'b0;

        // one more fully random matrix
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                ld_mat[i][j] = int'($urandom_range(0, 65535)) - 32768;
            end
        end
        exp_mat = ld_mat;
        load_rows(0, SIZE - 1, 2);
        stream_check(1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
